iir_biquad_cascade: RTL and testbench

Time-multiplexed cascade of N_SECTIONS second-order (biquad) IIR sections, each Direct Form I, sharing one multiplier–accumulator sequenced by an FSM. It is the parametrised successor to the single-section 2nd-order filter and sits in the same DSP chain between the ADC sample stream and the DAC/GPIO output path. It adds three things: a valid/ready sample handshake, saturating per-section outputs, and double-buffered coefficients with atomic commit.

---
 rtl/iir_biquad_cascade.sv | 205 ++++++++++++++++++++
 tb/tb_iir_biquad_cascade.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_biquad_cascade.sv
// iir_biquad_cascade: N-section Direct Form I biquad cascade sharing one MAC, with double-buffered coefficients.
// Defining IIR_CASCADE_GAIN_EN adds a saturating output gain stage (GAIN state and gain port).
module iir_biquad_cascade #(
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int N_SECTIONS  = 4,
    parameter int LOG_A0      = COEFF_WIDTH - 2,
    parameter int ACC_WIDTH   = DATA_WIDTH + COEFF_WIDTH + 3,
    parameter int ADDR_WIDTH  = $clog2(5 * N_SECTIONS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  x_in,
    output logic                   out_valid,
    output logic [DATA_WIDTH-1:0]  y_out,
    input  logic                   coef_wr_en,
    input  logic [ADDR_WIDTH-1:0]  coef_addr,
    input  logic [COEFF_WIDTH-1:0] coef_data,
    input  logic                   coef_commit,
    output logic                   coef_busy,
    output logic                   sat_flag,
    input  logic                   sat_clr
`ifdef IIR_CASCADE_GAIN_EN
    ,
    input  logic [COEFF_WIDTH-1:0] gain
`endif
);
    localparam int NC = 5 * N_SECTIONS;
    localparam int SW = N_SECTIONS > 1 ? $clog2(N_SECTIONS) : 1;
    localparam int PW = DATA_WIDTH + COEFF_WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] VMAX = {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] VMIN = ~VMAX;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
`ifdef IIR_CASCADE_GAIN_EN
        SCALE,
        GAIN
`else
        SCALE
`endif
    } state_t;

    state_t state_q, state_d;
    logic signed [COEFF_WIDTH-1:0] shadow_q [NC];
    logic signed [COEFF_WIDTH-1:0] shadow_d [NC];
    logic signed [COEFF_WIDTH-1:0] active_q [NC];
    logic signed [COEFF_WIDTH-1:0] active_d [NC];
    logic signed [DATA_WIDTH-1:0]  x1_q [N_SECTIONS];
    logic signed [DATA_WIDTH-1:0]  x1_d [N_SECTIONS];
    logic signed [DATA_WIDTH-1:0]  x2_q [N_SECTIONS];
    logic signed [DATA_WIDTH-1:0]  x2_d [N_SECTIONS];
    logic signed [DATA_WIDTH-1:0]  y1_q [N_SECTIONS];
    logic signed [DATA_WIDTH-1:0]  y1_d [N_SECTIONS];
    logic signed [DATA_WIDTH-1:0]  y2_q [N_SECTIONS];
    logic signed [DATA_WIDTH-1:0]  y2_d [N_SECTIONS];
    logic signed [DATA_WIDTH-1:0]  xs_q, xs_d, y_out_q, y_out_d, mul_x, clip_v;
    logic signed [COEFF_WIDTH-1:0] mul_c;
    logic signed [PW-1:0]          prod;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d, sc_in;
    logic [SW-1:0]                 s_q, s_d;
    logic [2:0]                    k_q, k_d;
    logic [ADDR_WIDTH-1:0]         cidx;
    logic                          out_valid_q, out_valid_d, busy_q, busy_d, sat_q, sat_d, clip_hi, clip_lo;

    // Shared multiplier: coefficient/history operand chosen by section and MAC step
    always_comb begin
        cidx  = ADDR_WIDTH'(5 * int'(s_q) + int'(k_q));
        mul_c = active_q[cidx];
        mul_x = k_q == 3'd0 ? xs_q : k_q == 3'd1 ? x1_q[s_q] : k_q == 3'd2 ? x2_q[s_q] :
                k_q == 3'd3 ? y1_q[s_q] : y2_q[s_q];
`ifdef IIR_CASCADE_GAIN_EN
        if (state_q == GAIN) begin
            mul_c = $signed(gain);
            mul_x = xs_q;
        end
        prod  = PW'(mul_c) * PW'(mul_x);
        sc_in = state_q == SCALE ? acc_q >>> LOG_A0 : ACC_WIDTH'(prod) >>> LOG_A0;
`else
        prod  = PW'(mul_c) * PW'(mul_x);
        sc_in = acc_q >>> LOG_A0;
`endif
        clip_hi = sc_in > VMAX;
        clip_lo = sc_in < VMIN;
        clip_v  = clip_hi ? {1'b0, {(DATA_WIDTH-1){1'b1}}} :
                  clip_lo ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : sc_in[DATA_WIDTH-1:0];
    end

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        active_d    = active_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        y1_d        = y1_q;
        y2_d        = y2_q;
        xs_d        = xs_q;
        y_out_d     = y_out_q;
        acc_d       = acc_q;
        s_d         = s_q;
        k_d         = k_q;
        out_valid_d = 1'b0;
        sat_d       = sat_q;
        busy_d      = busy_q | coef_commit;
        if (coef_wr_en && coef_addr < ADDR_WIDTH'(NC))
            shadow_d[coef_addr] = $signed(coef_data);
        // Bank swap only between samples, so a sample never mixes old and new coefficients
        if (state_q == IDLE && busy_d) begin
            active_d = shadow_d;
            busy_d   = 1'b0;
        end
        case (state_q)
            IDLE: if (in_valid) begin
                xs_d    = $signed(x_in);
                acc_d   = '0;
                s_d     = '0;
                k_d     = '0;
                state_d = MAC;
            end
            MAC: begin
                acc_d = k_q < 3'd3 ? acc_q + ACC_WIDTH'(prod) : acc_q - ACC_WIDTH'(prod);
                k_d   = k_q == 3'd4 ? 3'd0 : k_q + 3'd1;
                if (k_q == 3'd4)
                    state_d = SCALE;
            end
            SCALE: begin
                sat_d      = sat_q | clip_hi | clip_lo;
                x2_d[s_q]  = x1_q[s_q];
                x1_d[s_q]  = xs_q;
                y2_d[s_q]  = y1_q[s_q];
                y1_d[s_q]  = clip_v;
                xs_d       = clip_v;
                acc_d      = '0;
                if (s_q != SW'(N_SECTIONS - 1)) begin
                    s_d     = s_q + SW'(1);
                    state_d = MAC;
                end else begin
`ifdef IIR_CASCADE_GAIN_EN
                    state_d = GAIN;
`else
                    y_out_d     = clip_v;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
`endif
                end
            end
`ifdef IIR_CASCADE_GAIN_EN
            GAIN: begin
                sat_d       = sat_q | clip_hi | clip_lo;
                y_out_d     = clip_v;
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
        if (sat_clr)
            sat_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shadow_q    <= '{default: '0};
            active_q    <= '{default: '0};
            x1_q        <= '{default: '0};
            x2_q        <= '{default: '0};
            y1_q        <= '{default: '0};
            y2_q        <= '{default: '0};
            xs_q        <= '0;
            y_out_q     <= '0;
            acc_q       <= '0;
            s_q         <= '0;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            y1_q        <= y1_d;
            y2_q        <= y2_d;
            xs_q        <= xs_d;
            y_out_q     <= y_out_d;
            acc_q       <= acc_d;
            s_q         <= s_d;
            k_q         <= k_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            sat_q       <= sat_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = out_valid_q;
    assign y_out     = y_out_q;
    assign coef_busy = busy_q;
    assign sat_flag  = sat_q;
endmodule

// File: tb/tb_iir_biquad_cascade.sv
// tb_iir_biquad_cascade: per-sample arithmetic model checked every cycle, plus directed literal expectations.
module tb_iir_biquad_cascade;
    localparam int NS  = 4;
    localparam int NC  = 5 * NS;
    localparam int LA0 = 14;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] x_in = '0;
    logic        out_valid;
    logic [15:0] y_out;
    logic        coef_wr_en = 1'b0;
    logic [4:0]  coef_addr = '0;
    logic [15:0] coef_data = '0;
    logic        coef_commit = 1'b0;
    logic        coef_busy;
    logic        sat_flag;
    logic        sat_clr = 1'b0;

    int nchk = 0;
    int nerr = 0;
    int tcyc = 0;

    iir_biquad_cascade dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
        .out_valid(out_valid), .y_out(y_out), .coef_wr_en(coef_wr_en), .coef_addr(coef_addr),
        .coef_data(coef_data), .coef_commit(coef_commit), .coef_busy(coef_busy),
        .sat_flag(sat_flag), .sat_clr(sat_clr)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        tcyc++;
    end

    task automatic check(input string name, input longint got, input longint exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Model: whole-sample arithmetic at accept time, results released at the documented edges
    int m_sh[NC], m_act[NC];
    int hx1[NS], hx2[NS], hy1[NS], hy2[NS];
    bit s_sat[NS];
    bit m_busy, m_sat, m_inflight, m_valid;
    int m_y, m_res, m_t0, m_edge;

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            m_sh[i]  = 0;
            m_act[i] = 0;
        end
        for (int s = 0; s < NS; s++) begin
            hx1[s] = 0; hx2[s] = 0; hy1[s] = 0; hy2[s] = 0; s_sat[s] = 0;
        end
        m_busy = 0; m_sat = 0; m_inflight = 0; m_valid = 0; m_y = 0; m_edge = 0; m_t0 = 0;
    endtask

    task automatic run_sample(input int x);
        int v;
        longint acc, q;
        v = x;
        for (int s = 0; s < NS; s++) begin
            acc = longint'(m_act[5*s]) * v + longint'(m_act[5*s+1]) * hx1[s] + longint'(m_act[5*s+2]) * hx2[s]
                - longint'(m_act[5*s+3]) * hy1[s] - longint'(m_act[5*s+4]) * hy2[s];
            q = acc >>> LA0;
            s_sat[s] = q > 32767 || q < -32768;
            q = q > 32767 ? 32767 : q < -32768 ? -32768 : q;
            hx2[s] = hx1[s]; hx1[s] = v; hy2[s] = hy1[s]; hy1[s] = int'(q);
            v = int'(q);
        end
        m_res = v;
    endtask

    task automatic model_edge();
        bit idle, pend;
        int d;
        m_edge++;
        idle = !m_inflight;
        m_valid = 0;
        d = m_edge - m_t0;
        if (sat_clr) m_sat = 0;
        else if (m_inflight && d % 6 == 0 && s_sat[d/6-1]) m_sat = 1;
        if (m_inflight && d == 6 * NS) begin
            m_inflight = 0;
            m_valid = 1;
            m_y = m_res;
        end
        if (coef_wr_en && int'(coef_addr) < NC) m_sh[coef_addr] = int'($signed(coef_data));
        pend = m_busy || coef_commit;
        if (idle && pend) begin
            m_act = m_sh;
            m_busy = 0;
        end else m_busy = pend;
        if (idle && in_valid) begin
            run_sample(int'($signed(x_in)));
            m_inflight = 1;
            m_t0 = m_edge;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else model_edge();
    end

    initial forever begin
        @(negedge clk);
        check("cyc_in_ready", longint'(in_ready), longint'(!m_inflight));
        check("cyc_out_valid", longint'(out_valid), longint'(m_valid));
        check("cyc_y_out", longint'($signed(y_out)), longint'(m_y));
        check("cyc_coef_busy", longint'(coef_busy), longint'(m_busy));
        check("cyc_sat_flag", longint'(sat_flag), longint'(m_sat));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        coef_wr_en = 1'b1;
        coef_addr  = 5'(a);
        coef_data  = 16'(d);
        tick();
        coef_wr_en = 1'b0;
    endtask

    task automatic commit();
        coef_commit = 1'b1;
        tick();
        coef_commit = 1'b0;
    endtask

    task automatic send(input int x, output int t);
        int n;
        n = 0;
        in_valid = 1'b1;
        x_in = 16'(x);
        while (!in_ready && n < 300) begin
            tick();
            n++;
        end
        check("accept_ready", longint'(in_ready), 1);
        tick();
        t = tcyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int y, output int t);
        int n;
        n = 0;
        while (!out_valid && n < 300) begin
            tick();
            n++;
        end
        check("out_valid_seen", longint'(out_valid), 1);
        y = int'($signed(y_out));
        t = tcyc;
    endtask

    initial begin
        int ta, to, y, t1, t2, t3, nv;
        int imp_x[4];
        int imp_y[4];
        imp_x = '{1000, 0, 0, 0};
        imp_y = '{1000, 500, 250, 125};
        in_valid = 1'b1; x_in = 16'd123; coef_wr_en = 1'b1; coef_data = 16'h4000; coef_commit = 1'b1;
        repeat (3) tick();
        check("rst_y_out", longint'(y_out), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_coef_busy", longint'(coef_busy), 0);
        check("rst_sat_flag", longint'(sat_flag), 0);
        in_valid = 1'b0; coef_wr_en = 1'b0; coef_commit = 1'b0; rst_n = 1'b1;
        tick();
        send(500, ta); wait_out(y, to);
        check("zero_coef_y", y, 0);

        for (int s = 0; s < NS; s++) wr(5 * s, 16384);
        commit();
        check("idle_commit_busy", longint'(coef_busy), 0);
        send(1000, ta); wait_out(y, to);
        check("pass_y", y, 1000);
        check("pass_latency", to - ta, 24);
        send(0, ta); wait_out(y, to);
        check("flush_y", y, 0);

        wr(3, -8192); commit();
        for (int i = 0; i < 4; i++) begin
            send(imp_x[i], ta); wait_out(y, to);
            check("impulse_y", y, imp_y[i]);
        end

        wr(3, 0); wr(0, 32767); commit();
        send(30000, ta); wait_out(y, to);
        check("sat_y", y, 32767);
        check("sat_flag_set", longint'(sat_flag), 1);
        sat_clr = 1'b1; tick(); sat_clr = 1'b0;
        check("sat_flag_clr", longint'(sat_flag), 0);

        send(1000, ta);
        wr(0, 16384); commit();
        check("busy_inflight", longint'(coef_busy), 1);
        wait_out(y, to);
        check("old_bank_y", y, 1999);
        check("busy_at_out", longint'(coef_busy), 1);
        tick();
        check("busy_after_idle", longint'(coef_busy), 0);
        send(1000, ta); wait_out(y, to);
        check("new_bank_y", y, 1000);

        in_valid = 1'b1; x_in = 16'd100;
        wait_out(y, t1); tick();
        wait_out(y, t2); tick();
        wait_out(y, t3);
        in_valid = 1'b0;
        check("b2b_period1", t2 - t1, 25);
        check("b2b_period2", t3 - t2, 25);
        check("b2b_y", y, 100);

        send(1000, ta);
        tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        nv = 0;
        repeat (40) begin
            tick();
            nv += int'(out_valid);
        end
        check("abort_no_out", nv, 0);
        wr(0, 16384); wr(1, 16384); wr(3, -8192);
        for (int s = 1; s < NS; s++) wr(5 * s, 16384);
        commit();
        send(0, ta); wait_out(y, to);
        check("hist_cleared_y", y, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
endmodule
